// File: rtl/unary_mac_array.sv
// ---------------------------------------------------------------------------
// unary_mac_array
//   Multi-lane unary multiply-accumulate engine. Each accepted beat adds the
//   signed count of coincident ones (a & b, signed by pos) across LANES lanes
//   into a signed accumulator. After STREAM_LEN accepted beats the total is
//   offered on a valid/ready handshake.
//
//   Build option UNARY_MAC_SAT_EN: when defined the accumulator saturates at
//   the signed WIDTH-bit limits; otherwise it wraps modulo 2^WIDTH. The sticky
//   overflow flag behaves the same in both builds.
//
// Ports
//   clk, reset            clock, async active-high reset
//   start                 begin a new window (only honoured in IDLE)
//   busy                  high while a window is in progress or awaiting pickup
//   in_valid / in_ready   beat handshake (in_ready high only in ACCUM)
//   a, b, pos             per-lane unary operands and product sign (1 = +1)
//   total                 signed accumulator value
//   total_valid/_ready    result handshake (valid only in DONE)
//   overflow              sticky signed overflow within the current window
//
// State | meaning
//   S_IDLE  | waiting for start; total holds the previous result
//   S_ACCUM | accepting beats until STREAM_LEN have been taken
//   S_DONE  | total is final and held until total_ready
// ---------------------------------------------------------------------------
module unary_mac_array #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 4,
  parameter int STREAM_LEN = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] pos,
  output logic [WIDTH-1:0] total,
  output logic             total_valid,
  input  logic             total_ready,
  output logic             overflow
);

  localparam int CNT_W = $clog2(STREAM_LEN + 1);
  localparam logic signed [WIDTH:0]   ONE     = (WIDTH+1)'(1);
  localparam logic        [CNT_W-1:0] LAST    = CNT_W'(STREAM_LEN - 1);
  localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         beat_cnt;
  logic signed [WIDTH-1:0]  acc, acc_nxt;
  logic signed [WIDTH:0]    delta, sum;
  logic                     accept, last_beat, sum_ovf;

  assign accept    = in_valid && (state == S_ACCUM);
  assign last_beat = (beat_cnt == LAST);

  always_comb begin
    delta = '0;
    for (int i = 0; i < LANES; i++) begin
      if (a[i] && b[i]) begin
        delta = pos[i] ? (delta + ONE) : (delta - ONE);
      end
    end
  end

  // One guard bit: the WIDTH+1 result leaves the signed WIDTH range exactly
  // when its top two bits disagree.
  assign sum     = {acc[WIDTH-1], acc} + delta;
  assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];

  always_comb begin
    acc_nxt = sum[WIDTH-1:0];
`ifdef UNARY_MAC_SAT_EN
    if (sum_ovf) begin
      acc_nxt = sum[WIDTH] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (accept && last_beat) state_nxt = S_DONE;
      S_DONE:  if (total_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      acc      <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc      <= acc_nxt;
      beat_cnt <= beat_cnt + CNT_W'(1);
      if (sum_ovf) overflow <= 1'b1;
    end
  end

  assign busy        = (state != S_IDLE);
  assign in_ready    = (state == S_ACCUM);
  assign total_valid = (state == S_DONE);
  assign total       = acc;

endmodule

// File: tb/tb_unary_mac_array.sv
module tb_unary_mac_array;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, total_ready;
  logic [3:0] a, b, pos;

  logic        busy, in_ready, total_valid, overflow;
  logic [15:0] total;
  logic        busy6, in_ready6, total_valid6, overflow6;
  logic [5:0]  total6;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer arithmetic per window.
  int m16, m6, mbeats;
  bit ov16, ov6, m_accum;

  unary_mac_array #(.WIDTH(16), .LANES(4), .STREAM_LEN(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .pos(pos),
    .total(total), .total_valid(total_valid), .total_ready(total_ready),
    .overflow(overflow));

  unary_mac_array #(.WIDTH(6), .LANES(4), .STREAM_LEN(8)) dut6 (
    .clk(clk), .reset(reset), .start(start), .busy(busy6),
    .in_valid(in_valid), .in_ready(in_ready6), .a(a), .b(b), .pos(pos),
    .total(total6), .total_valid(total_valid6), .total_ready(total_ready),
    .overflow(overflow6));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int step_acc(input int acc, input int d, input int w, output bit hit);
    int s  = acc + d;
    int lo = -(1 << (w - 1));
    int hi = (1 << (w - 1)) - 1;
    hit = (s > hi) || (s < lo);
    if (hit) begin
`ifdef UNARY_MAC_SAT_EN
      s = (s > hi) ? hi : lo;
`else
      s = s & ((1 << w) - 1);
      if (s > hi) s -= (1 << w);
`endif
    end
    return s;
  endfunction

  task automatic model_clear();
    m16 = 0; m6 = 0; mbeats = 0; ov16 = 0; ov6 = 0;
  endtask

  task automatic model_beat(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tp);
    int  d;
    bit  h;
    if (!m_accum) return;
    d = $countones(ta & tb & tp) - $countones(ta & tb & ~tp);
    m16 = step_acc(m16, d, 16, h); if (h) ov16 = 1;
    m6  = step_acc(m6,  d, 6,  h); if (h) ov6  = 1;
    mbeats++;
    if (mbeats == 8) m_accum = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
    model_clear(); m_accum = 1;
  endtask

  task automatic drive(input bit v, input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tp);
    in_valid = v; a = ta; b = tb; pos = tp;
    if (v) model_beat(ta, tb, tp);
    tick();
    in_valid = 0;
  endtask

  task automatic handshake();
    total_ready = 1; tick(); total_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (total_valid !== 1'b0) begin errors++; $display("FAIL reset_total_valid got %b want 0", total_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (total !== 16'h0) begin errors++; $display("FAIL reset_total got %h want 0000", total); end
    reset = 0; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  // All lanes +1: 32 in 16 bits, overflows the 6-bit instance.
  task automatic test_all_pos();
    do_start();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_latency in_ready %b busy %b want 1 1", in_ready, busy); end
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'hF, 4'hF, 4'hF);
      if (i == 6) begin
        checks++; if (total_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", total_valid); end
      end
    end
    checks++; if (total_valid !== 1'b1) begin errors++; $display("FAIL pos_valid_latency got %b want 1", total_valid); end
    checks++; if (total !== 16'd32 || total !== 16'(m16)) begin errors++; $display("FAIL pos_total got %0d want 32", total); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pos_overflow got %b want 0", overflow); end
    checks++; if (total6 !== 6'(m6)) begin errors++; $display("FAIL w6_total got %h want %h", total6, 6'(m6)); end
    checks++; if (overflow6 !== 1'b1 || !ov6) begin errors++; $display("FAIL w6_overflow got %b want 1", overflow6); end
    handshake();
    checks++; if (busy !== 1'b0 || total !== 16'd32) begin errors++; $display("FAIL idle_hold busy %b total %0d want 0 32", busy, total); end
  endtask

  task automatic test_all_neg();
    do_start();
    for (int i = 0; i < 8; i++) drive(1, 4'hF, 4'hF, 4'h0);
    checks++; if (total !== 16'hFFE0) begin errors++; $display("FAIL neg_total got %h want ffe0", total); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL neg_overflow got %b want 0", overflow); end
    checks++; if (total6 !== 6'h20 || overflow6 !== 1'b0) begin errors++; $display("FAIL w6_neg got %h/%b want 20/0", total6, overflow6); end
    handshake();
  endtask

  task automatic test_mixed();
    do_start();
    for (int i = 0; i < 8; i++) drive(1, 4'b0111, 4'b0011, 4'b0001);
    checks++; if (total !== 16'h0 || total_valid !== 1'b1) begin errors++; $display("FAIL mixed_total got %h/%b want 0000/1", total, total_valid); end
    handshake();
  endtask

  // 7 x +4 then +3 reaches exactly +31 in 6 bits without overflow.
  task automatic test_boundary();
    do_start();
    for (int i = 0; i < 7; i++) drive(1, 4'hF, 4'hF, 4'hF);
    drive(1, 4'b0111, 4'b0111, 4'b0111);
    checks++; if (total6 !== 6'h1F || overflow6 !== 1'b0) begin errors++; $display("FAIL w6_max got %h/%b want 1f/0", total6, overflow6); end
    handshake();
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    logic [15:0] held;
    do_start();
    while (mbeats < 8 && cyc < 40) begin
      start = (cyc == 3);
      drive(cyc % 2 == 0, 4'($urandom), 4'($urandom), 4'($urandom));
      start = 0;
      cyc++;
    end
    checks++; if (mbeats != 8) begin errors++; $display("FAIL bp_timeout beats %0d want 8", mbeats); end
    checks++; if (total_valid !== 1'b1 || total !== 16'(m16)) begin errors++; $display("FAIL bp_total got %h/%b want %h/1", total, total_valid, 16'(m16)); end
    checks++; if (overflow !== ov16 || total6 !== 6'(m6) || overflow6 !== ov6) begin errors++; $display("FAIL bp_misc got %b %h %b want %b %h %b", overflow, total6, overflow6, ov16, 6'(m6), ov6); end
    held = 16'(m16);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      drive(1, 4'hF, 4'hF, 4'hF);
      start = 0;
      checks++; if (total_valid !== 1'b1 || in_ready !== 1'b0 || total !== held) begin errors++; $display("FAIL bp_hold%0d valid %b ready %b total %h want 1 0 %h", k, total_valid, in_ready, total, held); end
    end
    handshake();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || total_valid !== 1'b0) begin errors++; $display("FAIL bp_idle busy %b ready %b valid %b want 0 0 0", busy, in_ready, total_valid); end
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      int cyc = 0;
      do_start();
      while (mbeats < 8 && cyc < 60) begin
        drive($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom), 4'($urandom));
        cyc++;
      end
      checks++; if (mbeats != 8 || total_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_valid got %b beats %0d want 1 8", w, total_valid, mbeats); end
      checks++; if (total !== 16'(m16) || overflow !== ov16) begin errors++; $display("FAIL rnd%0d_total got %h/%b want %h/%b", w, total, overflow, 16'(m16), ov16); end
      checks++; if (total6 !== 6'(m6) || overflow6 !== ov6) begin errors++; $display("FAIL rnd%0d_w6 got %h/%b want %h/%b", w, total6, overflow6, 6'(m6), ov6); end
      repeat ($urandom_range(0, 2)) tick();
      handshake();
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 3; i++) drive(1, 4'hF, 4'hF, 4'hF);
    reset = 1; #1;
    checks++; if (busy !== 0 || in_ready !== 0 || total_valid !== 0 || overflow !== 0 || total !== 16'h0)
      begin errors++; $display("FAIL mid_reset busy %b ready %b valid %b ovf %b total %h want all 0", busy, in_ready, total_valid, overflow, total); end
    m_accum = 0; model_clear();
    tick(); reset = 0; tick();
    do_start();
    for (int i = 0; i < 8; i++) drive(1, 4'hF, 4'hF, 4'hF);
    checks++; if (total !== 16'd32 || total_valid !== 1'b1) begin errors++; $display("FAIL after_abort got %0d/%b want 32/1", total, total_valid); end
    handshake();
  endtask

  initial begin
    reset = 1; start = 0; in_valid = 0; total_ready = 0;
    a = 0; b = 0; pos = 0; m_accum = 0;
    model_clear();
    test_reset();
    test_all_pos();
    test_all_neg();
    test_mixed();
    test_boundary();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
